// File: rtl/ecc_pkg.sv
// Shared encodings for the elliptic-curve point sequencer: GFAU opcodes,
// register-file indices, FSM states and the microcode word layout.
package ecc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_INV = 2'b11
  } gf_op_e;

  typedef enum logic [2:0] {
    R_X1 = 3'd0,
    R_Y1 = 3'd1,
    R_X2 = 3'd2,
    R_Y2 = 3'd3,
    R_A  = 3'd4,
    R_T0 = 3'd5,
    R_T1 = 3'd6,
    R_T2 = 3'd7
  } reg_idx_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  typedef struct packed {
    gf_op_e   op;
    reg_idx_e src_a;
    reg_idx_e src_b;
    reg_idx_e dst;
    logic     last;
  } ucode_t;

  localparam int         ROM_DEPTH = 23;
  localparam logic [4:0] PC_DBL    = 5'd0;
  localparam logic [4:0] PC_ADD    = 5'd13;

  function automatic ucode_t uc(gf_op_e op, reg_idx_e sa, reg_idx_e sb, reg_idx_e d, logic l);
    ucode_t w;
    w = '{op: op, src_a: sa, src_b: sb, dst: d, last: l};
    return w;
  endfunction

endpackage

// File: rtl/ecc_point_seq_if.sv
// Request/response bus between the point sequencer and the GF(p) arithmetic unit.
interface ecc_point_seq_if #(parameter int SIZE = 32);
  logic [SIZE-1:0] gfau_in_0;
  logic [SIZE-1:0] gfau_in_1;
  logic [SIZE-1:0] gfau_prime;
  logic [SIZE-1:0] gfau_result;
  logic [1:0]      gfau_op;
  logic            gfau_start;
  logic            gfau_done;

  modport master (output gfau_in_0, gfau_in_1, gfau_op, gfau_prime, gfau_start,
                  input  gfau_done, gfau_result);
  modport slave  (input  gfau_in_0, gfau_in_1, gfau_op, gfau_prime, gfau_start,
                  output gfau_done, gfau_result);
endinterface

// File: rtl/ecc_ucode_rom.sv
// Microcode for affine point doubling (pc 0..12) and addition (pc 13..22).
// Result lands in T1 (x) and T2 (y); lambda is kept in T0.
module ecc_ucode_rom
  import ecc_pkg::*;
(
  input  logic [4:0] pc,
  output ucode_t     insn
);

  always_comb begin
    // out-of-range pc decodes as a terminating no-op so a runaway pc still finishes
    insn = uc(OP_ADD, R_T0, R_T0, R_T0, 1'b1);
    case (pc)
      5'd0:  insn = uc(OP_MUL, R_X1, R_X1, R_T0, 1'b0);
      5'd1:  insn = uc(OP_ADD, R_T0, R_T0, R_T1, 1'b0);
      5'd2:  insn = uc(OP_ADD, R_T1, R_T0, R_T0, 1'b0);
      5'd3:  insn = uc(OP_ADD, R_T0, R_A,  R_T0, 1'b0);
      5'd4:  insn = uc(OP_ADD, R_Y1, R_Y1, R_T1, 1'b0);
      5'd5:  insn = uc(OP_INV, R_T1, R_T1, R_T1, 1'b0);
      5'd6:  insn = uc(OP_MUL, R_T0, R_T1, R_T0, 1'b0);
      5'd7:  insn = uc(OP_MUL, R_T0, R_T0, R_T1, 1'b0);
      5'd8:  insn = uc(OP_SUB, R_T1, R_X1, R_T1, 1'b0);
      5'd9:  insn = uc(OP_SUB, R_T1, R_X1, R_T1, 1'b0);
      5'd10: insn = uc(OP_SUB, R_X1, R_T1, R_T2, 1'b0);
      5'd11: insn = uc(OP_MUL, R_T0, R_T2, R_T2, 1'b0);
      5'd12: insn = uc(OP_SUB, R_T2, R_Y1, R_T2, 1'b1);
      5'd13: insn = uc(OP_SUB, R_Y2, R_Y1, R_T0, 1'b0);
      5'd14: insn = uc(OP_SUB, R_X2, R_X1, R_T1, 1'b0);
      5'd15: insn = uc(OP_INV, R_T1, R_T1, R_T1, 1'b0);
      5'd16: insn = uc(OP_MUL, R_T0, R_T1, R_T0, 1'b0);
      5'd17: insn = uc(OP_MUL, R_T0, R_T0, R_T1, 1'b0);
      5'd18: insn = uc(OP_SUB, R_T1, R_X1, R_T1, 1'b0);
      5'd19: insn = uc(OP_SUB, R_T1, R_X2, R_T1, 1'b0);
      5'd20: insn = uc(OP_SUB, R_X1, R_T1, R_T2, 1'b0);
      5'd21: insn = uc(OP_MUL, R_T0, R_T2, R_T2, 1'b0);
      5'd22: insn = uc(OP_SUB, R_T2, R_Y1, R_T2, 1'b1);
      default: ;
    endcase
  end

endmodule

// File: rtl/ecc_point_seq.sv
// Affine point double/add sequencer: walks a microcode program and hands every
// field operation to an external GFAU, one operation in flight at a time.
module ecc_point_seq
  import ecc_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              start,
  input  logic              mode,
  input  logic [SIZE-1:0]   x1,
  input  logic [SIZE-1:0]   y1,
  input  logic [SIZE-1:0]   x2,
  input  logic [SIZE-1:0]   y2,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   prime,
  ecc_point_seq_if.master   gfau,
  output logic [SIZE-1:0]   x3,
  output logic [SIZE-1:0]   y3,
  output logic              busy,
  output logic              done,
  output logic              inf,
  output logic              err
);

  localparam int WCW = $clog2(TIMEOUT + 2);

  state_e          state, state_nxt;
  logic [SIZE-1:0] rf [8];
  logic [4:0]      pc;
  logic [WCW-1:0]  wcnt;
  ucode_t          insn;
  logic            is_dbl, spec_inf, timeout, wr_en;
  logic [SIZE-1:0] t1_fwd, t2_fwd;

  ecc_ucode_rom u_rom (.pc(pc), .insn(insn));

  // A doubling of a point with y=0 has no tangent slope, same as the vertical add.
  assign is_dbl   = !mode || (x1 == x2 && y1 == y2);
  assign spec_inf = (is_dbl && y1 == '0) || (mode && x1 == x2 && y1 != y2);
  assign timeout  = (wcnt == WCW'(TIMEOUT));

  // The final op writes T2 on the same edge x3/y3 load, so forward the result.
  assign t1_fwd = (wr_en && insn.dst == R_T1) ? gfau.gfau_result : rf[R_T1];
  assign t2_fwd = (wr_en && insn.dst == R_T2) ? gfau.gfau_result : rf[R_T2];

  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_FIN);
    wr_en     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = spec_inf ? S_FIN : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (gfau.gfau_done) begin
          wr_en     = 1'b1;
          state_nxt = insn.last ? S_FIN : S_ISSUE;
        end else if (timeout) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Results are loaded on entry to FIN so they are valid while done is high.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      pc              <= '0;
      wcnt            <= '0;
      x3              <= '0;
      y3              <= '0;
      inf             <= 1'b0;
      err             <= 1'b0;
      gfau.gfau_start <= 1'b0;
      gfau.gfau_in_0  <= '0;
      gfau.gfau_in_1  <= '0;
      gfau.gfau_op    <= 2'b00;
      gfau.gfau_prime <= '0;
    end else begin
      gfau.gfau_start <= 1'b0;
      case (state)
        S_LOAD: begin
          rf[R_X1]        <= x1;
          rf[R_Y1]        <= y1;
          rf[R_X2]        <= x2;
          rf[R_Y2]        <= y2;
          rf[R_A]         <= a;
          gfau.gfau_prime <= prime;
          pc              <= is_dbl ? PC_DBL : PC_ADD;
          inf             <= spec_inf;
          err             <= 1'b0;
          if (spec_inf) begin
            x3 <= '0;
            y3 <= '0;
          end
        end
        S_ISSUE: begin
          gfau.gfau_in_0  <= rf[insn.src_a];
          gfau.gfau_in_1  <= rf[insn.src_b];
          gfau.gfau_op    <= insn.op;
          gfau.gfau_start <= 1'b1;
          wcnt            <= '0;
        end
        S_WAIT: begin
          if (gfau.gfau_done) begin
            rf[insn.dst] <= gfau.gfau_result;
            if (insn.last) begin
              x3 <= t1_fwd;
              y3 <= t2_fwd;
            end else begin
              pc <= pc + 5'd1;
            end
          end else if (timeout) begin
            err <= 1'b1;
            x3  <= '0;
            y3  <= '0;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_point_seq.sv
// Bench for ecc_point_seq: behavioural 3-cycle GFAU plus an affine-formula
// reference model over GF(p).
module tb_ecc_point_seq;
  import ecc_pkg::*;

  localparam int SIZE    = 32;
  localparam int TIMEOUT = 1023;
  localparam int LAT     = 3;
  localparam logic [SIZE-1:0] PBIG = 32'd2147483647;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            start = 1'b0;
  logic            mode  = 1'b0;
  logic [SIZE-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, a = '0, prime = '0;
  logic [SIZE-1:0] x3, y3;
  logic            busy, done, inf, err;

  int vec  = 0;
  int errs = 0;

  ecc_point_seq_if #(.SIZE(SIZE)) gif ();

  ecc_point_seq #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .start(start), .mode(mode),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .a(a), .prime(prime),
    .gfau(gif), .x3(x3), .y3(y3), .busy(busy), .done(done), .inf(inf), .err(err)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- behavioural GFAU ----------------
  function automatic longint unsigned mpow(input longint unsigned b, input longint unsigned e,
                                           input longint unsigned m);
    longint unsigned r = 1;
    b = b % m;
    while (e > 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [SIZE-1:0] gf_eval(input logic [1:0] op, input logic [SIZE-1:0] u,
                                              input logic [SIZE-1:0] v, input logic [SIZE-1:0] p);
    longint unsigned uu = u, vv = v, pp = p, r;
    case (op)
      2'b00:   r = (uu + vv) % pp;
      2'b01:   r = (uu + pp - vv) % pp;
      2'b10:   r = (uu * vv) % pp;
      default: r = mpow(uu, pp - 2, pp);
    endcase
    return r[SIZE-1:0];
  endfunction

  bit              hang     = 1'b0;
  int              pend_cnt = 0;
  logic [SIZE-1:0] pend_res = '0;

  initial begin
    gif.gfau_done   = 1'b0;
    gif.gfau_result = '0;
  end

  always @(negedge i_clk) begin
    gif.gfau_done = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        gif.gfau_done   = 1'b1;
        gif.gfau_result = pend_res;
      end
    end
    if (gif.gfau_start && !hang) begin
      pend_res = gf_eval(gif.gfau_op, gif.gfau_in_0, gif.gfau_in_1, gif.gfau_prime);
      pend_cnt = LAT;
    end
  end

  // ---------------- reference model: affine chord/tangent formulas ----------------
  function automatic longint md(input longint v, input longint p);
    longint r = v % p;
    return (r < 0) ? r + p : r;
  endfunction

  function automatic longint ref_inv(input longint v, input longint p);
    longint t = 0, nt = 1, r = p, nr = md(v, p), q, tmp;
    while (nr != 0) begin
      q = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    return md(t, p);
  endfunction

  task automatic ref_point(input bit m, input longint px1, input longint py1, input longint px2,
                           input longint py2, input longint pa, input longint pp,
                           output bit rinf, output logic [SIZE-1:0] rx, output logic [SIZE-1:0] ry);
    longint lam, xr;
    bit dbl;
    dbl  = !m || (px1 == px2 && py1 == py2);
    rinf = 1'b0; rx = '0; ry = '0;
    if (dbl ? (py1 == 0) : (px1 == px2)) begin
      rinf = 1'b1;
      return;
    end
    if (dbl) lam = md(md(md(px1 * px1, pp) * 3 + pa, pp) * ref_inv(2 * py1, pp), pp);
    else     lam = md(md(py2 - py1, pp) * ref_inv(px2 - px1, pp), pp);
    xr = md(lam * lam - px1 - (dbl ? px1 : px2), pp);
    rx = SIZE'(xr);
    ry = SIZE'(md(lam * md(px1 - xr, pp) - py1, pp));
  endtask

  function automatic int exp_cycles(input int nops);
    return (nops == 0) ? 2 : 2 + nops * (LAT + 2);
  endfunction

  // ---------------- stimulus driver ----------------
  task automatic run_op(input bit m, input logic [SIZE-1:0] px1, input logic [SIZE-1:0] py1,
                        input logic [SIZE-1:0] px2, input logic [SIZE-1:0] py2,
                        input logic [SIZE-1:0] pa, input logic [SIZE-1:0] pp, input bit poke,
                        output int cyc, output int nst, output int last_st);
    mode = m; x1 = px1; y1 = py1; x2 = px2; y2 = py2; a = pa; prime = pp;
    start = 1'b1;
    cyc = 0; nst = 0; last_st = -1;
    do begin
      @(posedge i_clk); #1;
      cyc++;
      start = poke && (cyc == 6);
      if (start) begin x1 = ~px1; y1 = ~py1; mode = ~m; end
      if (gif.gfau_start) begin nst++; last_st = cyc; end
    end while (!done && cyc < TIMEOUT + 200);
    if (!done) begin
      vec++; errs++;
      $display("FAIL run_op_done: done not seen within %0d cycles", cyc);
    end
    start = 1'b0;
    @(posedge i_clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    vec++;
    if ({x3, y3, busy, done, inf, err, gif.gfau_start, gif.gfau_in_0, gif.gfau_in_1,
         gif.gfau_op, gif.gfau_prime} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: x3=%0h y3=%0h busy=%b done=%b inf=%b err=%b st=%b in0=%0h in1=%0h op=%0d pr=%0h, need all 0",
               x3, y3, busy, done, inf, err, gif.gfau_start, gif.gfau_in_0, gif.gfau_in_1, gif.gfau_op, gif.gfau_prime);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle: busy=%b done=%b, need 0 0", busy, done);
    end
  endtask

  task automatic test_double();
    int cyc, nst, ls;
    bit rinf;
    logic [SIZE-1:0] ex, ey, px, py, pa, pp;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin px = 3; py = 10; pa = 1; pp = 23; end
      else begin
        pp = PBIG; px = $urandom % pp; py = 1 + ($urandom % (pp - 1)); pa = $urandom % pp;
      end
      run_op(1'b0, px, py, $urandom, $urandom, pa, pp, 1'b0, cyc, nst, ls);
      ref_point(1'b0, px, py, 0, 0, pa, pp, rinf, ex, ey);
      if (i == 0) begin ex = 7; ey = 12; end
      vec++;
      if ({inf, err, x3, y3} !== {rinf, 1'b0, ex, ey}) begin
        errs++;
        $display("FAIL double_result[%0d]: got x3=%0d y3=%0d inf=%b err=%b, need x3=%0d y3=%0d inf=%b err=0",
                 i, x3, y3, inf, err, ex, ey, rinf);
      end
      vec++;
      if (nst !== 13 || cyc !== exp_cycles(13)) begin
        errs++;
        $display("FAIL double_timing[%0d]: starts=%0d cycles=%0d, need 13 %0d", i, nst, cyc, exp_cycles(13));
      end
      vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errs++;
        $display("FAIL double_idle[%0d]: busy=%b done=%b after completion, need 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_add();
    int cyc, nst, ls;
    bit rinf;
    logic [SIZE-1:0] ex, ey, px, py, qx, qy, pa, pp;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin px = 3; py = 10; qx = 9; qy = 7; pa = 1; pp = 23; end
      else begin
        pp = PBIG; px = $urandom % pp; py = $urandom % pp; qy = $urandom % pp; pa = $urandom % pp;
        qx = $urandom % pp;
        if (qx == px) qx = (px + 1) % pp;
      end
      run_op(1'b1, px, py, qx, qy, pa, pp, 1'b0, cyc, nst, ls);
      ref_point(1'b1, px, py, qx, qy, pa, pp, rinf, ex, ey);
      if (i == 0) begin ex = 17; ey = 20; end
      vec++;
      if ({inf, err, x3, y3} !== {rinf, 1'b0, ex, ey}) begin
        errs++;
        $display("FAIL add_result[%0d]: got x3=%0d y3=%0d inf=%b err=%b, need x3=%0d y3=%0d inf=%b err=0",
                 i, x3, y3, inf, err, ex, ey, rinf);
      end
      vec++;
      if (nst !== 10 || cyc !== exp_cycles(10)) begin
        errs++;
        $display("FAIL add_timing[%0d]: starts=%0d cycles=%0d, need 10 %0d", i, nst, cyc, exp_cycles(10));
      end
    end
  endtask

  task automatic test_special();
    int cyc, nst, ls, enst;
    bit rinf, m;
    logic [SIZE-1:0] ex, ey, px, py, qx, qy, pa, pp;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin m = 1; px = 3; py = 10; qx = 3; qy = 13; pa = 1; pp = 23; end
        1: begin m = 1; px = 3; py = 10; qx = 3; qy = 10; pa = 1; pp = 23; end
        2: begin m = 0; pp = PBIG; px = $urandom % pp; py = 0; qx = $urandom; qy = $urandom; pa = $urandom % pp; end
        default: begin
          m = 1; pp = PBIG; px = $urandom % pp; py = $urandom % pp; qx = px; qy = (py + 5) % pp; pa = $urandom % pp;
        end
      endcase
      run_op(m, px, py, qx, qy, pa, pp, 1'b0, cyc, nst, ls);
      ref_point(m, px, py, qx, qy, pa, pp, rinf, ex, ey);
      enst = rinf ? 0 : 13;
      vec++;
      if ({inf, err, x3, y3} !== {rinf, 1'b0, ex, ey}) begin
        errs++;
        $display("FAIL special_result[%0d]: got x3=%0d y3=%0d inf=%b err=%b, need x3=%0d y3=%0d inf=%b err=0",
                 i, x3, y3, inf, err, ex, ey, rinf);
      end
      vec++;
      if (nst !== enst || cyc !== exp_cycles(enst)) begin
        errs++;
        $display("FAIL special_timing[%0d]: starts=%0d cycles=%0d, need %0d %0d", i, nst, cyc, enst, exp_cycles(enst));
      end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, nst, ls;
    bit rinf;
    logic [SIZE-1:0] ex, ey, px, py, qx, qy, pa;
    px = $urandom % PBIG; py = $urandom % PBIG; qy = $urandom % PBIG; pa = $urandom % PBIG;
    qx = (px + 1 + ($urandom % 1000)) % PBIG;
    run_op(1'b1, px, py, qx, qy, pa, PBIG, 1'b1, cyc, nst, ls);
    ref_point(1'b1, px, py, qx, qy, pa, PBIG, rinf, ex, ey);
    vec++;
    if ({inf, err, x3, y3} !== {rinf, 1'b0, ex, ey} || nst !== 10) begin
      errs++;
      $display("FAIL busy_start_ignored: got x3=%0d y3=%0d inf=%b starts=%0d, need x3=%0d y3=%0d inf=%b starts=10",
               x3, y3, inf, nst, ex, ey, rinf);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, k = 0, cyc, nst, ls;
    bit bad = 0;
    mode = 1'b0; x1 = 3; y1 = 10; a = 1; prime = 23; start = 1'b1;
    @(posedge i_clk); #1;
    start = 1'b0;
    while (n < 5 && k < 200) begin
      @(posedge i_clk); #1;
      k++;
      if (gif.gfau_start) n++;
    end
    vec++;
    if (n != 5) begin
      errs++;
      $display("FAIL midreset_reach_op5: saw %0d gfau_start pulses, need 5", n);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    vec++;
    if ({x3, y3, busy, done, inf, err, gif.gfau_start, gif.gfau_in_0, gif.gfau_in_1,
         gif.gfau_op, gif.gfau_prime} !== '0) begin
      errs++;
      $display("FAIL midreset_outputs: x3=%0d y3=%0d busy=%b in0=%0d in1=%0d op=%0d pr=%0d, need all 0",
               x3, y3, busy, gif.gfau_in_0, gif.gfau_in_1, gif.gfau_op, gif.gfau_prime);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    repeat (6) begin
      @(posedge i_clk); #1;
      if (busy || done || err || inf || gif.gfau_start || x3 != 0 || y3 != 0) bad = 1;
    end
    vec++;
    if (bad) begin
      errs++;
      $display("FAIL midreset_stray_done: sequencer reacted after release (busy=%b x3=%0d y3=%0d), need idle with 0 results",
               busy, x3, y3);
    end
    run_op(1'b1, 3, 10, 9, 7, 1, 23, 1'b0, cyc, nst, ls);
    vec++;
    if ({inf, err, x3, y3} !== {1'b0, 1'b0, 32'd17, 32'd20} || nst !== 10) begin
      errs++;
      $display("FAIL midreset_recover: got x3=%0d y3=%0d inf=%b err=%b starts=%0d, need 17 20 0 0 10",
               x3, y3, inf, err, nst);
    end
  endtask

  task automatic test_timeout();
    int cyc, nst, ls, extra = 0;
    hang = 1'b1;
    run_op(1'b0, 3, 10, 0, 0, 1, 23, 1'b1, cyc, nst, ls);
    vec++;
    if ({err, inf, x3, y3} !== {1'b1, 1'b0, 64'd0}) begin
      errs++;
      $display("FAIL timeout_flags: err=%b inf=%b x3=%0d y3=%0d, need 1 0 0 0", err, inf, x3, y3);
    end
    vec++;
    if (nst !== 1 || cyc - ls !== TIMEOUT + 1) begin
      errs++;
      $display("FAIL timeout_latency: starts=%0d done-after-start=%0d, need 1 %0d", nst, cyc - ls, TIMEOUT + 1);
    end
    repeat (5) begin
      @(posedge i_clk); #1;
      if (gif.gfau_start || busy) extra++;
    end
    vec++;
    if (extra != 0 || err !== 1'b1) begin
      errs++;
      $display("FAIL timeout_idle: %0d busy/issue cycles after abort, err=%b, need 0 and err=1", extra, err);
    end
    hang = 1'b0;
  endtask

  initial begin
    test_reset();
    test_double();
    test_add();
    test_special();
    test_start_while_busy();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/ecc_point_seq.md
ECC_POINT_SEQ -- requirements
Module: ecc_point_seq

Interface
REQ-001 SHALL have parameter SIZE, default 32, meaning GF(p) operand width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 1023, meaning maximum cycles to wait for gfau_done before abort.
REQ-003 SHALL have ports: i_clk  in  1  single clock, rising edge.
REQ-004 SHALL have ports: i_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: start  in  1  one-cycle request; mode  in  1  0=point double, 1=point add.
REQ-006 SHALL have ports: x1, y1, x2, y2, a, prime  in  SIZE each  affine operands, curve coefficient and field prime; x2/y2 ignored when mode=0.
REQ-007 SHALL have ports: gfau_in_0, gfau_in_1  out  SIZE  operands; gfau_op  out  2  00 add, 01 sub, 10 mul, 11 inverse (in_0 only); gfau_prime  out  SIZE.
REQ-008 SHALL have ports: gfau_start  out  1  issue pulse; gfau_done  in  1  completion pulse; gfau_result  in  SIZE.
REQ-009 SHALL have ports: x3, y3  out  SIZE  result; busy  out  1; done  out  1  completion pulse; inf  out  1  result is point at infinity; err  out  1  timeout abort.

Function
REQ-010 SHALL hold an 8-entry SIZE-bit register file: R0=X1, R1=Y1, R2=X2, R3=Y2, R4=A, R5=T0, R6=T1, R7=T2.
REQ-011 SHALL run states IDLE -> LOAD -> ISSUE -> WAIT -> (ISSUE | FIN) -> IDLE; start is honoured only in IDLE, ignored otherwise.
REQ-012 In LOAD (1 cycle) SHALL latch all operands and mode, clear inf/err, set pc to the program start for mode.
REQ-013 In LOAD SHALL detect special cases and go directly to FIN with inf=1, x3=y3=0, no GFAU issue: mode=0 and y1=0; mode=1 and x1=x2 and y1!=y2.
REQ-014 mode=1 with x1=x2 and y1=y2 SHALL execute the doubling program.
REQ-015 Doubling program (13 ops) SHALL be: T0=X1*X1; T1=T0+T0; T0=T1+T0; T0=T0+A; T1=Y1+Y1; T1=inv T1; T0=T0*T1; T1=T0*T0; T1=T1-X1; T1=T1-X1; T2=X1-T1; T2=T0*T2; T2=T2-Y1.
REQ-016 Addition program (10 ops) SHALL be: T0=Y2-Y1; T1=X2-X1; T1=inv T1; T0=T0*T1; T1=T0*T0; T1=T1-X1; T1=T1-X2; T2=X1-T1; T2=T0*T2; T2=T2-Y1.
REQ-017 Each microinstruction SHALL be a ROM word {op, srcA, srcB, dst, last}; both programs in one 23-entry ROM indexed by 5-bit pc.
REQ-018 In ISSUE SHALL drive gfau_in_0/in_1/op from ROM[pc] and assert gfau_start for exactly one cycle, then enter WAIT.
REQ-019 gfau_in_0, gfau_in_1, gfau_op, gfau_prime SHALL stay stable from ISSUE until the cycle gfau_done is sampled.
REQ-020 In WAIT, on gfau_done=1 SHALL write gfau_result to R[dst]; if last go to FIN, else pc+1 and go to ISSUE (min 2 cycles per op excluding GFAU latency).
REQ-021 gfau_done outside WAIT SHALL be ignored; gfau_done in same cycle as gfau_start is not possible and need not be handled.
REQ-022 A wait counter SHALL clear on ISSUE; if it reaches TIMEOUT in WAIT, SHALL go to FIN with err=1, x3=y3=0.
REQ-023 In FIN SHALL load x3=T1, y3=T2 (unless inf/err), pulse done for one cycle, return to IDLE.
REQ-024 busy SHALL be 1 in all states except IDLE; x3, y3, inf, err SHALL hold until the next LOAD.
REQ-025 No modular reduction SHALL be performed locally; all arithmetic is delegated to the GFAU.

Reset
REQ-026 i_rst=0 SHALL asynchronously force IDLE, pc=0, register file=0, wait counter=0, and all outputs (x3, y3, busy, done, inf, err, gfau_start, gfau_in_0, gfau_in_1, gfau_op, gfau_prime) to 0.
REQ-027 Reset mid-operation SHALL abandon the program; a late gfau_done after release SHALL be ignored.

Structure
REQ-028 Opcode encodings, register indices, state encoding and ROM program-start addresses SHALL live in a shared package ecc_pkg.
REQ-029 The microcode ROM SHALL be a sub-module ecc_ucode_rom (combinational, pc in, instruction word out).

Verification (curve y^2=x^3+x+1 mod 23, behavioural GFAU with 3-cycle latency)
REQ-030 mode=0, P=(3,10), a=1, prime=23 -> 13 gfau_start pulses, done with x3=7, y3=12, inf=0.
REQ-031 mode=1, P=(3,10), Q=(9,7) -> 10 gfau_start pulses, x3=17, y3=20.
REQ-032 mode=1, P=(3,10), Q=(3,13) -> no gfau_start, inf=1, done 2 cycles after start; mode=1, P=Q=(3,10) -> x3=7, y3=12.
REQ-033 GFAU model never returns done -> err=1, done pulse TIMEOUT+1 cycles after last gfau_start; start while busy ignored.
REQ-034 i_rst=0 asserted during op 5 -> all outputs 0 immediately; stray gfau_done after release has no effect; next start completes correctly.
